// File: rtl/ysyx_22050854_pkg.sv
// Shared definitions for the ysyx_22050854 core slice: fetch FSM encoding,
// AXI response codes and the architectural reset PC.
package ysyx_22050854_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } ifu_state_e;

  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [31:0] RESET_PC  = 32'h8000_0000;

endpackage

// File: rtl/ysyx_22050854_ifu_perf.sv
// Fetch performance counters: consumed instructions and memory-wait cycles.
// Only instantiated when YSYX_22050854_IFU_PERF_EN is defined.
module ysyx_22050854_ifu_perf (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_inc,
  input  logic        wait_inc,
  output logic [63:0] fetch_cnt,
  output logic [63:0] wait_cnt
);

  // Both counters wrap naturally modulo 2^64.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_cnt <= 64'h0;
      wait_cnt  <= 64'h0;
    end else begin
      if (fetch_inc) fetch_cnt <= fetch_cnt + 64'd1;
      if (wait_inc)  wait_cnt  <= wait_cnt + 64'd1;
    end
  end

endmodule

// File: rtl/ysyx_22050854_ifu.sv
// Instruction fetch unit: single-outstanding 64-bit read per PC, result held
// toward IF/ID until consumed or flushed. Counters gated by YSYX_22050854_IFU_PERF_EN.
module ysyx_22050854_ifu
  import ysyx_22050854_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fetch_pc,
  input  logic        flush,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_fault,
  output logic        mem_arvalid,
  input  logic        mem_arready,
  output logic [31:0] mem_araddr,
  input  logic        mem_rvalid,
  output logic        mem_rready,
  input  logic [63:0] mem_rdata,
  input  logic [1:0]  mem_rresp,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_wait_cnt
);

  ifu_state_e  state, state_nxt;
  logic [31:0] req_pc;
  logic        discard;
  logic [31:0] inst_q;
  logic [31:0] pc_q;
  logic        fault_q;
  logic        resp_fire;
  logic        resp_keep;

  function automatic logic [31:0] select_word(input logic [63:0] rdata, input logic hi);
    return hi ? rdata[63:32] : rdata[31:0];
  endfunction

  assign resp_fire = (state == S_WAIT) && mem_rvalid;
  // A response is kept only if no flush hit this transaction, including this cycle.
  assign resp_keep = resp_fire && !discard && !flush;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ:  if (mem_arready) state_nxt = S_WAIT;
      S_WAIT: if (mem_rvalid)  state_nxt = resp_keep ? S_HOLD : S_IDLE;
      S_HOLD: if (flush || id_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      req_pc  <= RESET_PC;
      discard <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE) req_pc <= fetch_pc;
      if (resp_fire)
        discard <= 1'b0;
      else if (flush && (state == S_REQ || state == S_WAIT))
        discard <= 1'b1;
    end
  end

  // Response capture into the IF/ID-facing holding registers
  always_ff @(posedge clock) begin
    if (reset) begin
      inst_q  <= 32'h0;
      pc_q    <= 32'h0;
      fault_q <= 1'b0;
    end else if (resp_keep) begin
      inst_q  <= (mem_rresp != RESP_OKAY) ? 32'h0 : select_word(mem_rdata, req_pc[2]);
      pc_q    <= req_pc;
      fault_q <= (mem_rresp != RESP_OKAY);
    end
  end

  assign id_valid    = (state == S_HOLD) && !flush;
  assign id_inst     = inst_q;
  assign id_pc       = pc_q;
  assign id_fault    = fault_q;
  assign mem_arvalid = (state == S_REQ);
  assign mem_araddr  = (state == S_REQ) ? {req_pc[31:3], 3'b000} : 32'h0;
  assign mem_rready  = (state == S_WAIT);

`ifdef YSYX_22050854_IFU_PERF_EN
  logic mem_phase;
  assign mem_phase = (state == S_REQ) || (state == S_WAIT);

  ysyx_22050854_ifu_perf u_perf (
    .clock     (clock),
    .reset     (reset),
    .fetch_inc (id_valid & id_ready),
    .wait_inc  (mem_phase),
    .fetch_cnt (perf_fetch_cnt),
    .wait_cnt  (perf_wait_cnt)
  );
`else
  assign perf_fetch_cnt = 64'h0;
  assign perf_wait_cnt  = 64'h0;
`endif

endmodule

// File: tb/tb_ysyx_22050854_ifu.sv
// Directed bench for ysyx_22050854_ifu: vector table of fetches plus
// hand-written stall / flush sequences against a small memory responder.
module tb_ysyx_22050854_ifu;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fetch_pc = 32'h0;
  logic        flush = 1'b0;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_fault;
  logic        mem_arvalid;
  logic        mem_arready;
  logic [31:0] mem_araddr;
  logic        mem_rvalid = 1'b0;
  logic        mem_rready;
  logic [63:0] mem_rdata = 64'h0;
  logic [1:0]  mem_rresp = 2'b00;
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_wait_cnt;

  ysyx_22050854_ifu dut (
    .clock          (clock),
    .reset          (reset),
    .fetch_pc       (fetch_pc),
    .flush          (flush),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_fault       (id_fault),
    .mem_arvalid    (mem_arvalid),
    .mem_arready    (mem_arready),
    .mem_araddr     (mem_araddr),
    .mem_rvalid     (mem_rvalid),
    .mem_rready     (mem_rready),
    .mem_rdata      (mem_rdata),
    .mem_rresp      (mem_rresp),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_wait_cnt  (perf_wait_cnt)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: arready after ar_lat cycles of arvalid, data on the next cycle.
  int          ar_lat = 0;
  int          ar_wait = 0;
  logic [63:0] cfg_rdata = 64'h0;
  logic [1:0]  cfg_rresp = 2'b00;

  assign mem_arready = mem_arvalid && (ar_wait >= ar_lat);

  always @(posedge clock) begin
    if (reset) begin
      ar_wait    <= 0;
      mem_rvalid <= 1'b0;
      mem_rdata  <= 64'h0;
      mem_rresp  <= 2'b00;
    end else begin
      if (mem_arvalid && mem_arready) begin
        ar_wait    <= 0;
        mem_rvalid <= 1'b1;
        mem_rdata  <= cfg_rdata;
        mem_rresp  <= cfg_rresp;
      end else if (mem_arvalid) begin
        ar_wait <= ar_wait + 1;
      end
      if (mem_rvalid && mem_rready) mem_rvalid <= 1'b0;
    end
  end

  // Bus observers feeding the end-of-test protocol and counter checks.
  int          ar_hs = 0;
  int          wait_model = 0;
  int          fetch_model = 0;
  int          addr_glitch = 0;
  int          ar_drop = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] last_araddr = 32'h0;

  always @(posedge clock) begin
    if (reset) begin
      pend <= 1'b0;
    end else begin
      if (mem_arvalid && mem_arready) begin
        ar_hs       <= ar_hs + 1;
        last_araddr <= mem_araddr;
      end
      if (mem_arvalid || mem_rready) wait_model <= wait_model + 1;
      if (id_valid && id_ready) fetch_model <= fetch_model + 1;
      if (pend && !mem_arvalid) ar_drop <= ar_drop + 1;
      if (pend && mem_arvalid && (mem_araddr != pend_addr)) addr_glitch <= addr_glitch + 1;
      pend      <= mem_arvalid && !mem_arready;
      pend_addr <= mem_araddr;
    end
  end

  typedef struct {
    logic [31:0] pc;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic [31:0] exp_inst;
    logic [31:0] exp_addr;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[5];

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!id_valid && cyc < 80) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  // Called at a negedge with id_valid high: consume, load the next fetch, wait for valid.
  task automatic hs_wait(input logic [31:0] npc, input logic [63:0] nd, input logic [1:0] nr,
                         output int cyc);
    fetch_pc  = npc;
    cfg_rdata = nd;
    cfg_rresp = nr;
    id_ready  = 1'b1;
    cyc = 0;
    do begin
      @(negedge clock);
      id_ready = 1'b0;
      cyc++;
    end while (!id_valid && cyc < 80);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          cyc;
    int          h0;
    int          vs;
    logic        stable_ok;
    logic [63:0] pf;

    vecs[0] = '{32'h8000_0000, 64'h00100093_00000413, 2'b00, 32'h0000_0413, 32'h8000_0000, 1'b0};
    vecs[1] = '{32'h8000_0004, 64'h00100093_00000413, 2'b00, 32'h0010_0093, 32'h8000_0000, 1'b0};
    vecs[2] = '{32'h8000_123C, 64'hDEADBEEF_12345678, 2'b00, 32'hDEAD_BEEF, 32'h8000_1238, 1'b0};
    vecs[3] = '{32'h8000_0010, 64'hCAFEF00D_0BADC0DE, 2'b10, 32'h0000_0000, 32'h8000_0010, 1'b1};
    vecs[4] = '{32'h8000_0008, 64'h11111111_22222222, 2'b00, 32'h2222_2222, 32'h8000_0008, 1'b0};

    fetch_pc  = vecs[0].pc;
    cfg_rdata = vecs[0].rdata;
    cfg_rresp = vecs[0].rresp;
    repeat (3) @(negedge clock);
    chk("rst id_valid", id_valid, 0);
    chk("rst id_inst", id_inst, 0);
    chk("rst id_pc", id_pc, 0);
    chk("rst id_fault", id_fault, 0);
    chk("rst arvalid", mem_arvalid, 0);
    chk("rst rready", mem_rready, 0);
    chk("rst araddr", mem_araddr, 0);
    chk("rst perf_fetch", perf_fetch_cnt, 0);
    chk("rst perf_wait", perf_wait_cnt, 0);

    // Cycle 1 is the first cycle with reset low (IDLE); id_valid is due in cycle 4.
    reset = 1'b0;
    cyc = 0;
    while (!id_valid && cyc < 80) begin
      @(negedge clock);
      cyc++;
    end
    chk("first valid latency", cyc, 3);

    for (int i = 0; i < 5; i++) begin
      chk($sformatf("vec%0d id_inst", i), id_inst, vecs[i].exp_inst);
      chk($sformatf("vec%0d id_pc", i), id_pc, vecs[i].pc);
      chk($sformatf("vec%0d id_fault", i), id_fault, vecs[i].exp_fault);
      chk($sformatf("vec%0d araddr", i), last_araddr, vecs[i].exp_addr);
      if (i < 4) begin
        hs_wait(vecs[i+1].pc, vecs[i+1].rdata, vecs[i+1].rresp, cyc);
        chk($sformatf("vec%0d hs-to-valid", i + 1), cyc, 4);
      end
    end

    // Downstream stall: everything held, no new request.
    h0 = ar_hs;
    stable_ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (!id_valid || id_inst != 32'h2222_2222 || id_pc != 32'h8000_0008 || mem_arvalid)
        stable_ok = 1'b0;
    end
    chk("stall stable", stable_ok, 1);
    chk("stall no ar", ar_hs, h0);

    // Handshake, then flush with a new PC while arready is delayed.
    fetch_pc  = 32'h8000_0100;
    cfg_rdata = 64'h55667788_99AABBCC;
    cfg_rresp = 2'b00;
    ar_lat    = 3;
    id_ready  = 1'b1;
    @(negedge clock);
    id_ready = 1'b0;
    chk("post-hs idle arvalid", mem_arvalid, 0);
    @(negedge clock);
    chk("arvalid 2 after hs", mem_arvalid, 1);
    chk("req araddr", mem_araddr, 32'h8000_0100);
    flush    = 1'b1;
    fetch_pc = 32'h8000_0208;
    @(negedge clock);
    flush = 1'b0;
    vs = 0;
    cyc = 0;
    while (ar_hs < h0 + 2 && cyc < 80) begin
      if (id_valid) vs++;
      @(negedge clock);
      cyc++;
    end
    chk("flushed resp dropped", vs, 0);
    chk("refetch issued", ar_hs, h0 + 2);
    wait_valid(cyc);
    ar_lat = 0;
    chk("post-flush id_pc", id_pc, 32'h8000_0208);
    chk("post-flush id_inst", id_inst, 32'h99AA_BBCC);
    chk("post-flush araddr", last_araddr, 32'h8000_0208);

    // Flush wins over id_ready in HOLD.
    pf = perf_fetch_cnt;
    flush    = 1'b1;
    id_ready = 1'b1;
    #1;
    chk("flush masks id_valid", id_valid, 0);
    @(negedge clock);
    flush    = 1'b0;
    id_ready = 1'b0;
    chk("flush no consume", perf_fetch_cnt, pf);
    cyc = 1;
    while (!id_valid && cyc < 80) begin
      @(negedge clock);
      cyc++;
    end
    chk("hold-flush refetch latency", cyc, 4);
    chk("hold-flush refetch pc", id_pc, 32'h8000_0208);

    // Flush in the same cycle the response arrives.
    fetch_pc  = 32'h8000_0300;
    cfg_rdata = 64'hAAAA0001_BBBB0002;
    id_ready  = 1'b1;
    @(negedge clock);
    id_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("wait rvalid", {mem_rvalid, mem_rready}, 2'b11);
    h0 = ar_hs;
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    chk("same-cycle flush drops", id_valid, 0);
    wait_valid(cyc);
    chk("same-cycle refetch ar", ar_hs, h0 + 1);
    chk("same-cycle refetch pc", id_pc, 32'h8000_0300);
    chk("same-cycle refetch inst", id_inst, 32'hBBBB_0002);

    hs_wait(32'h8000_0404, 64'h12340001_56780002, 2'b00, cyc);
    chk("final inst", id_inst, 32'h1234_0001);

    chk("araddr stable until arready", addr_glitch, 0);
    chk("arvalid not withdrawn", ar_drop, 0);
`ifdef YSYX_22050854_IFU_PERF_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, 64'(fetch_model));
    chk("perf_wait_cnt", perf_wait_cnt, 64'(wait_model));
`else
    chk("perf_fetch_cnt tied", perf_fetch_cnt, 0);
    chk("perf_wait_cnt tied", perf_wait_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
